// File: rtl/risc_pkg.sv
// Shared types and width helpers for the scoreboard hazard unit.
// Exports reg_addr_w/lat_w, the hazard-cause and flush-state enums, and R0.
package risc_pkg;

  function automatic int reg_addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int lat_w(input int m);
    return (m > 0) ? $clog2(m + 1) : 1;
  endfunction

  typedef enum logic [1:0] {
    HZ_NONE,
    HZ_RAW,
    HZ_WAW,
    HZ_PORT
  } haz_cause_e;

  typedef enum logic {
    S_RUN,
    S_FLUSH
  } fl_state_e;

  localparam int R0 = 0;

endpackage

// File: rtl/risc_hazard_unit_if.sv
// ID/EX hazard bus: decode fields and branch pulse in, pipeline controls out.
// master = decode/execute side, slave = hazard unit; perf ports under RISC_HAZ_PERF_EN.
interface risc_hazard_unit_if
  import risc_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int REG_CNT = 8,
  parameter int MAX_LAT = 4
);
  localparam int AW = reg_addr_w(REG_CNT);
  localparam int LW = lat_w(MAX_LAT);

  if (DATA_W < 1 || REG_CNT < 2 || MAX_LAT < 1) begin : g_bad_cfg
    $error("risc_hazard_unit_if: bad parameters");
  end

  logic          id_valid;
  logic [AW-1:0] id_rs_a;
  logic [AW-1:0] id_rs_b;
  logic          id_uses_a;
  logic          id_uses_b;
  logic [AW-1:0] id_rd;
  logic          id_writes;
  logic [LW-1:0] id_lat;
  logic          ex_branch_taken;

  logic               issue;
  logic               stall;
  logic               flush;
  logic               fwd_a;
  logic               fwd_b;
  logic               wb_valid;
  logic [AW-1:0]      wb_rd;
  logic [REG_CNT-1:0] busy_mask;
`ifdef RISC_HAZ_PERF_EN
  logic [DATA_W-1:0]  stall_cnt;
  logic [DATA_W-1:0]  flush_cnt;
`endif

  modport master (
    output id_valid, id_rs_a, id_rs_b,
    output id_uses_a, id_uses_b,
    output id_rd, id_writes, id_lat,
    output ex_branch_taken,
    input  issue, stall, flush,
    input  fwd_a, fwd_b,
    input  wb_valid, wb_rd, busy_mask
`ifdef RISC_HAZ_PERF_EN
    , input stall_cnt, flush_cnt
`endif
  );

  modport slave (
    input  id_valid, id_rs_a, id_rs_b,
    input  id_uses_a, id_uses_b,
    input  id_rd, id_writes, id_lat,
    input  ex_branch_taken,
    output issue, stall, flush,
    output fwd_a, fwd_b,
    output wb_valid, wb_rd, busy_mask
`ifdef RISC_HAZ_PERF_EN
    , output stall_cnt, flush_cnt
`endif
  );

endinterface

// File: rtl/risc_sb_entry.sv
// One scoreboard slot: latency down-counter with load priority.
// Ports: clk, reset(n), load, lat, lat_p1 -> is_one, is_busy, eq_lat.
module risc_sb_entry #(
  parameter int LW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [LW-1:0] lat,
  input  logic [LW:0]   lat_p1,
  output logic          is_one,
  output logic          is_busy,
  output logic          eq_lat
);

  logic [LW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= lat;
    end else if (cnt != '0) begin
      cnt <= cnt - LW'(1);
    end
  end

  assign is_busy = (cnt != '0);
  assign is_one  = (cnt == LW'(1));
  // Would land on the new entry's write-back slot after this edge.
  assign eq_lat  = ({1'b0, cnt} == lat_p1);

endmodule

// File: rtl/risc_hazard_unit.sv
// Scoreboard stall/forward/flush controller between ID and EX.
// Ports: clk, reset (async active-low), bus (slave); RISC_HAZ_PERF_EN adds perf counters.
module risc_hazard_unit
  import risc_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int REG_CNT   = 8,
  parameter int MAX_LAT   = 4,
  parameter int FLUSH_CYC = 1
) (
  input logic              clk,
  input logic              reset,
  risc_hazard_unit_if.slave bus
);

  localparam int AW = reg_addr_w(REG_CNT);
  localparam int LW = lat_w(MAX_LAT);
  localparam int FW = lat_w(FLUSH_CYC);
  localparam logic [LW-1:0] LMAX = LW'(MAX_LAT);

  if (DATA_W < 1 || FLUSH_CYC < 1) begin : g_bad_cfg
    $error("risc_hazard_unit: bad parameters");
  end

  logic [LW-1:0]      lat;
  logic [LW:0]        lat_p1;
  logic [REG_CNT-1:0] busy;
  logic [REG_CNT-1:0] one;
  logic [REG_CNT-1:0] eq_lat;
  logic               raw_a;
  logic               raw_b;
  logic               waw;
  logic               port;
  logic               rd_live;
  logic               hazard;
  logic               go;
  logic               stall;
  haz_cause_e         cause;
  logic [AW-1:0]      wb_rd;

  fl_state_e          st;
  logic [FW-1:0]      fcnt;
  logic               flush_r;

  // Out-of-range latency is folded to a single cycle.
  always_comb begin
    lat = bus.id_lat;
    if (bus.id_lat == '0 || bus.id_lat > LMAX) begin
      lat = LW'(1);
    end
  end

  assign lat_p1 = {1'b0, lat} + (LW+1)'(1);

  assign busy[0]   = 1'b0;
  assign one[0]    = 1'b0;
  assign eq_lat[0] = 1'b0;

  for (genvar r = 1; r < REG_CNT; r++) begin : g_ent
    logic load;
    assign load = go && bus.id_writes &&
                  (bus.id_rd == AW'(r));
    risc_sb_entry #(.LW(LW)) u_ent (
      .clk     (clk),
      .reset   (reset),
      .load    (load),
      .lat     (lat),
      .lat_p1  (lat_p1),
      .is_one  (one[r]),
      .is_busy (busy[r]),
      .eq_lat  (eq_lat[r])
    );
  end

  // cnt==1 means the value is on the bypass this cycle.
  assign raw_a   = bus.id_uses_a && busy[bus.id_rs_a]
                   && !one[bus.id_rs_a];
  assign raw_b   = bus.id_uses_b && busy[bus.id_rs_b]
                   && !one[bus.id_rs_b];
  assign rd_live = bus.id_writes && (bus.id_rd != AW'(R0));
  assign waw     = rd_live && busy[bus.id_rd];
  assign port    = rd_live && (|eq_lat);

  always_comb begin
    cause = HZ_NONE;
    if (raw_a || raw_b) begin
      cause = HZ_RAW;
    end else if (waw) begin
      cause = HZ_WAW;
    end else if (port) begin
      cause = HZ_PORT;
    end
  end

  assign hazard = (cause != HZ_NONE);
  // Outputs are forced low while reset is held.
  assign go    = reset && bus.id_valid && !hazard && !flush_r;
  assign stall = reset && bus.id_valid && hazard && !flush_r;

  always_comb begin
    wb_rd = '0;
    for (int r = 1; r < REG_CNT; r++) begin
      if (one[r]) begin
        wb_rd = wb_rd | AW'(r);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st      <= S_RUN;
      fcnt    <= '0;
      flush_r <= 1'b0;
    end else if (bus.ex_branch_taken) begin
      st      <= S_FLUSH;
      fcnt    <= FW'(FLUSH_CYC);
      flush_r <= 1'b1;
    end else begin
      unique case (st)
        S_RUN: begin
          fcnt    <= '0;
          flush_r <= 1'b0;
        end
        S_FLUSH: begin
          if (fcnt <= FW'(1)) begin
            st      <= S_RUN;
            fcnt    <= '0;
            flush_r <= 1'b0;
          end else begin
            fcnt <= fcnt - FW'(1);
          end
        end
        default: begin
          st      <= S_RUN;
          fcnt    <= '0;
          flush_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.issue     = go;
  assign bus.stall     = stall;
  assign bus.flush     = flush_r;
  assign bus.fwd_a     = bus.id_uses_a && one[bus.id_rs_a];
  assign bus.fwd_b     = bus.id_uses_b && one[bus.id_rs_b];
  assign bus.wb_valid  = |one;
  assign bus.wb_rd     = wb_rd;
  assign bus.busy_mask = busy;

`ifdef RISC_HAZ_PERF_EN
  logic [DATA_W-1:0] stall_q;
  logic [DATA_W-1:0] flush_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall && stall_q != '1) begin
        stall_q <= stall_q + DATA_W'(1);
      end
      if (flush_r && flush_q != '1) begin
        flush_q <= flush_q + DATA_W'(1);
      end
    end
  end

  assign bus.stall_cnt = stall_q;
  assign bus.flush_cnt = flush_q;
`endif

endmodule

// File: tb/tb_risc_hazard_unit.sv
// Self-checking bench for risc_hazard_unit: directed steps plus random stream.
// Reference model tracks absolute write-back cycle per register.
module tb_risc_hazard_unit;
  import risc_pkg::*;

  localparam int DW = 16;
  localparam int RC = 8;
  localparam int ML = 4;
  localparam int FC = 2;
  localparam int AW = reg_addr_w(RC);
  localparam int LW = lat_w(ML);

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  risc_hazard_unit_if #(
    .DATA_W(DW), .REG_CNT(RC), .MAX_LAT(ML)
  ) bus ();

  risc_hazard_unit #(
    .DATA_W(DW), .REG_CNT(RC),
    .MAX_LAT(ML), .FLUSH_CYC(FC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int passed = 0;
  int fails = 0;
  int cyc = 0;
  int wb_at[RC];
  int flush_end = -1;
  int n_stall = 0;
  int n_flush = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h cyc=%0d",
             tag, obs, exp, cyc);
    end
  endtask

  task automatic model_clear();
    foreach (wb_at[r]) wb_at[r] = -1;
    flush_end = -1;
    n_stall = 0;
    n_flush = 0;
  endtask

  // One pipeline cycle: drive, check at negedge, advance the model.
  task automatic step(input string tag,
                      input bit v, input int rsa, input int rsb,
                      input bit ua, input bit ub,
                      input int rd, input bit w, input int lat,
                      input bit br,
                      output bit o_issue, output bit o_flush);
    int el, e_wbr, n_one;
    bit raw, waw, port, hz, fl;
    bit e_issue, e_stall, e_wbv;
    logic [RC-1:0] e_busy;
    bus.id_valid = v;
    bus.id_rs_a = AW'(rsa);
    bus.id_rs_b = AW'(rsb);
    bus.id_uses_a = ua;
    bus.id_uses_b = ub;
    bus.id_rd = AW'(rd);
    bus.id_writes = w;
    bus.id_lat = LW'(lat);
    bus.ex_branch_taken = br;
    @(negedge clk);
    el = (lat < 1 || lat > ML) ? 1 : lat;
    fl = reset && (cyc <= flush_end);
    raw = (ua && wb_at[rsa] > cyc) || (ub && wb_at[rsb] > cyc);
    waw = w && rd != 0 && wb_at[rd] >= cyc;
    port = 1'b0;
    foreach (wb_at[r])
      if (w && rd != 0 && wb_at[r] == cyc + el) port = 1'b1;
    hz = raw || waw || port;
    e_issue = reset && v && !hz && !fl;
    e_stall = reset && v && hz && !fl;
    e_wbv = 1'b0;
    e_wbr = 0;
    n_one = 0;
    e_busy = '0;
    foreach (wb_at[r]) begin
      if (wb_at[r] == cyc) begin
        e_wbv = 1'b1;
        e_wbr = r;
        n_one++;
      end
      if (wb_at[r] >= cyc) e_busy[r] = 1'b1;
    end
    chk({tag, ".one_wb"}, 32'(n_one <= 1), 32'd1);
    chk({tag, ".issue"}, 32'(bus.issue), 32'(e_issue));
    chk({tag, ".stall"}, 32'(bus.stall), 32'(e_stall));
    chk({tag, ".flush"}, 32'(bus.flush), 32'(fl));
    chk({tag, ".fwd_a"}, 32'(bus.fwd_a),
        32'(ua && wb_at[rsa] == cyc));
    chk({tag, ".fwd_b"}, 32'(bus.fwd_b),
        32'(ub && wb_at[rsb] == cyc));
    chk({tag, ".wb_valid"}, 32'(bus.wb_valid), 32'(e_wbv));
    chk({tag, ".wb_rd"}, 32'(bus.wb_rd), 32'(e_wbr));
    chk({tag, ".busy"}, 32'(bus.busy_mask), 32'(e_busy));
`ifdef RISC_HAZ_PERF_EN
    chk({tag, ".stall_cnt"}, 32'(bus.stall_cnt), 32'(n_stall));
    chk({tag, ".flush_cnt"}, 32'(bus.flush_cnt), 32'(n_flush));
`endif
    o_issue = bus.issue;
    o_flush = bus.flush;
    if (e_stall && n_stall < 65535) n_stall++;
    if (fl && n_flush < 65535) n_flush++;
    if (e_issue && w && rd != 0) wb_at[rd] = cyc + el;
    if (reset && br) flush_end = cyc + FC;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    bit a, b;
    for (int i = 0; i < n; i++)
      step("idle", 0, 0, 0, 0, 0, 0, 0, 1, 0, a, b);
  endtask

  initial begin
    bit iss, fl;
    int k, nf;
    model_clear();
    bus.id_valid = 0;
    bus.ex_branch_taken = 0;
    @(posedge clk);
    #1;

    // reset held with a valid instruction present
    step("rst0", 1, 0, 0, 0, 0, 5, 1, 2, 0, iss, fl);
    step("rst1", 1, 0, 0, 0, 0, 5, 1, 2, 1, iss, fl);
    reset = 1'b1;
    step("rel", 1, 0, 0, 0, 0, 5, 1, 2, 0, iss, fl);
    chk("rel.first_issue", 32'(iss), 32'd1);
    idle(4);

    // RAW then forward
    step("raw.prod", 1, 0, 0, 0, 0, 3, 1, 3, 0, iss, fl);
    for (k = 0; k < 8; k++) begin
      step("raw.cons", 1, 3, 0, 1, 0, 0, 0, 1, 0, iss, fl);
      if (iss) break;
    end
    chk("raw.stalls", 32'(k), 32'd2);
    idle(4);

    // WAW
    step("waw.first", 1, 0, 0, 0, 0, 2, 1, 4, 0, iss, fl);
    for (k = 0; k < 10; k++) begin
      step("waw.second", 1, 0, 0, 0, 0, 2, 1, 1, 0, iss, fl);
      if (iss) break;
    end
    chk("waw.stalls", 32'(k), 32'd4);
    idle(4);

    // write-port conflict
    step("port.a", 1, 0, 0, 0, 0, 1, 1, 3, 0, iss, fl);
    for (k = 0; k < 8; k++) begin
      step("port.b", 1, 0, 0, 0, 0, 4, 1, 2, 0, iss, fl);
      if (iss) break;
    end
    chk("port.stalls", 32'(k), 32'd1);
    idle(4);

    // branch flush, re-pulse, pending write-back on time
    nf = 0;
    step("br.prod", 1, 0, 0, 0, 0, 6, 1, 4, 0, iss, fl);
    step("br.p1", 1, 0, 0, 0, 0, 0, 0, 1, 1, iss, fl);
    for (int i = 0; i < 6; i++) begin
      step("br.run", 1, 0, 0, 0, 0, 0, 0, 1, i == 0, iss, fl);
      if (fl) nf++;
    end
    chk("br.flush_cycles", 32'(nf), 32'd3);
    idle(3);

    // r0 destination and out-of-range latencies
    step("r0.w", 1, 0, 0, 0, 0, 0, 1, 2, 0, iss, fl);
    chk("r0.issue", 32'(iss), 32'd1);
    idle(3);
    step("lat0", 1, 0, 0, 0, 0, 7, 1, 0, 0, iss, fl);
    idle(2);
    step("lat7", 1, 0, 0, 0, 0, 7, 1, 7, 0, iss, fl);
    idle(3);

    // random stream with a reset in the middle
    for (int i = 0; i < 400; i++) begin
      int lat;
      lat = ($urandom_range(0, 11) == 0) ?
            $urandom_range(5, 7) * int'($urandom_range(0, 1)) :
            int'($urandom_range(1, ML));
      if (i == 200) begin
        reset = 1'b0;
        model_clear();
        step("rnd.rst", 1, 0, 0, 0, 0, 3, 1, 2, 0, iss, fl);
        reset = 1'b1;
      end
      step("rnd", $urandom_range(0, 3) != 0,
           $urandom_range(0, RC - 1), $urandom_range(0, RC - 1),
           $urandom_range(0, 1), $urandom_range(0, 1),
           $urandom_range(0, RC - 1), $urandom_range(0, 3) != 0,
           lat, $urandom_range(0, 11) == 0, iss, fl);
    end
    idle(6);

    $display("%0d/%0d checks passed", passed, passed + fails);
    $finish;
  end

endmodule
